// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback port arbiter: FSM states,
// write-source codes and datapath widths.
package wb_arb_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int RD_W                 = 5;
    localparam int DATA_W               = 32;
    localparam int FIFO_DEPTH           = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_FORCE   = 2'd2
    } arbState_t;

    localparam logic SRC_PIPE = 1'b0;
    localparam logic SRC_LU   = 1'b1;

    // x0 is never a real destination, so it never matches for WAW purposes.
    function automatic logic rdMatch(input logic [RD_W-1:0] a, input logic [RD_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Two-entry queue of long-latency results. Each slot carries a valid bit that a
// younger in-order write to the same rd can clear while the slot stays queued.
module wb_arb_fifo
    import wb_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pushEn,
    input  logic              pushValid,
    input  logic [RD_W-1:0]   pushRd,
    input  logic [DATA_W-1:0] pushData,
    input  logic              popEn,
    input  logic              invEn,
    input  logic [RD_W-1:0]   invRd,
    output logic [1:0]        count,
    output logic              headPresent,
    output logic              headValid,
    output logic [RD_W-1:0]   headRd,
    output logic [DATA_W-1:0] headData,
    output logic              anyValidNext
);

    logic                  rdPtrReg;
    logic                  wrPtrReg;
    logic [1:0]            countReg;
    logic [FIFO_DEPTH-1:0] slotValid;
    logic [FIFO_DEPTH-1:0] slotValidNext;
    logic [RD_W-1:0]       slotRd   [FIFO_DEPTH];
    logic [DATA_W-1:0]     slotData [FIFO_DEPTH];

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : gSlot
            logic              validReg;
            logic [RD_W-1:0]   rdReg;
            logic [DATA_W-1:0] dataReg;
            logic              pushHere;
            logic              popHere;
            logic              invHere;

            assign pushHere = pushEn & (wrPtrReg == 1'(gi));
            assign popHere  = popEn & (rdPtrReg == 1'(gi));
            assign invHere  = invEn & validReg & rdMatch(rdReg, invRd);

            // A popped slot drops its valid bit, so validReg also means "occupied and live".
            assign slotValidNext[gi] = pushHere ? pushValid : (validReg & ~popHere & ~invHere);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    validReg <= 1'b0;
                    rdReg    <= '0;
                    dataReg  <= '0;
                end else begin
                    validReg <= slotValidNext[gi];
                    if (pushHere) begin
                        rdReg   <= pushRd;
                        dataReg <= pushData;
                    end
                end
            end

            assign slotValid[gi] = validReg;
            assign slotRd[gi]    = rdReg;
            assign slotData[gi]  = dataReg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtrReg <= 1'b0;
            wrPtrReg <= 1'b0;
            countReg <= 2'd0;
        end else begin
            if (pushEn) begin
                wrPtrReg <= ~wrPtrReg;
            end
            if (popEn) begin
                rdPtrReg <= ~rdPtrReg;
            end
            countReg <= countReg + {1'b0, pushEn} - {1'b0, popEn};
        end
    end

    assign count        = countReg;
    assign headPresent  = (countReg != 2'd0);
    assign headValid    = slotValid[rdPtrReg];
    assign headRd       = slotRd[rdPtrReg];
    assign headData     = slotData[rdPtrReg];
    assign anyValidNext = |slotValidNext;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the in-order pipeline and
// a long-latency unit, with WAW squashing and a starvation-forced stall.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_valid,
    input  logic              pipe_regwen,
    input  logic [RD_W-1:0]   pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              lu_valid,
    input  logic [RD_W-1:0]   lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    output logic              rf_we,
    output logic [RD_W-1:0]   rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_src,
    output logic              pipe_stall
);

    localparam logic [3:0] FORCE_AT = 4'(STARVE_LIMIT - 1);

    arbState_t         stateReg;
    logic [3:0]        waitCntReg;
    logic              pipeStallReg;
    logic              rfWeReg;
    logic [RD_W-1:0]   rfRdReg;
    logic [DATA_W-1:0] rfWdataReg;
    logic              rfSrcReg;

    logic              forceCycle;
    logic              pipeActive;
    logic              pipeGrant;
    logic              luAccept;
    logic              luHasRd;
    logic              bypassGrant;
    logic              headGrant;
    logic              popEn;
    logic              pushEn;
    logic              pushValid;
    logic              headStaysValid;
    logic              starveNow;

    logic [1:0]        fifoCount;
    logic              headPresent;
    logic              headValid;
    logic [RD_W-1:0]   headRd;
    logic [DATA_W-1:0] headData;
    logic              anyValidNext;

    assign forceCycle = (stateReg == ST_FORCE);
    assign pipeActive = pipe_valid & pipe_regwen & (pipe_rd != '0);
    // During the forced cycle the pipeline write is ignored; it is replayed next cycle.
    assign pipeGrant  = pipeActive & ~forceCycle;

    assign lu_ready   = (fifoCount != 2'd2);
    assign luAccept   = lu_valid & lu_ready;
    assign luHasRd    = (lu_rd != '0);

    assign popEn      = headPresent & ~pipeGrant;
    assign headGrant  = popEn & headValid;

    // Empty queue and idle pipeline: the result falls straight through to the port.
    assign bypassGrant = luAccept & luHasRd & ~headPresent & ~pipeActive;
    assign pushEn      = luAccept & luHasRd & ~bypassGrant;
    assign pushValid   = ~(pipeGrant & rdMatch(lu_rd, pipe_rd));

    assign headStaysValid = headValid & ~(pipeGrant & rdMatch(headRd, pipe_rd));
    assign starveNow      = (waitCntReg == FORCE_AT) & headStaysValid & ~popEn;

    wb_arb_fifo uFifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .pushEn       (pushEn),
        .pushValid    (pushValid),
        .pushRd       (lu_rd),
        .pushData     (lu_data),
        .popEn        (popEn),
        .invEn        (pipeGrant),
        .invRd        (pipe_rd),
        .count        (fifoCount),
        .headPresent  (headPresent),
        .headValid    (headValid),
        .headRd       (headRd),
        .headData     (headData),
        .anyValidNext (anyValidNext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg     <= ST_IDLE;
            waitCntReg   <= 4'd0;
            pipeStallReg <= 1'b0;
        end else begin
            if (popEn) begin
                waitCntReg <= 4'd0;
            end else if (headValid && (waitCntReg != 4'hF)) begin
                waitCntReg <= waitCntReg + 4'd1;
            end

            case (stateReg)
                ST_PENDING: begin
                    if (starveNow) begin
                        stateReg     <= ST_FORCE;
                        pipeStallReg <= 1'b1;
                    end else begin
                        stateReg     <= anyValidNext ? ST_PENDING : ST_IDLE;
                        pipeStallReg <= 1'b0;
                    end
                end
                default: begin
                    stateReg     <= anyValidNext ? ST_PENDING : ST_IDLE;
                    pipeStallReg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfWeReg    <= 1'b0;
            rfRdReg    <= '0;
            rfWdataReg <= '0;
            rfSrcReg   <= SRC_PIPE;
        end else begin
            rfWeReg <= pipeGrant | headGrant | bypassGrant;
            if (pipeGrant) begin
                rfRdReg    <= pipe_rd;
                rfWdataReg <= pipe_data;
                rfSrcReg   <= SRC_PIPE;
            end else if (headGrant) begin
                rfRdReg    <= headRd;
                rfWdataReg <= headData;
                rfSrcReg   <= SRC_LU;
            end else if (bypassGrant) begin
                rfRdReg    <= lu_rd;
                rfWdataReg <= lu_data;
                rfSrcReg   <= SRC_LU;
            end
        end
    end

    assign rf_we      = rfWeReg;
    assign rf_rd      = rfRdReg;
    assign rf_wdata   = rfWdataReg;
    assign rf_src     = rfSrcReg;
    assign pipe_stall = pipeStallReg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: a queue-based reference model predicts every output each
// cycle; directed sequences pin the model with hand-computed values.
module tb_wb_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid, pipe_regwen;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        rf_src;
    logic        pipe_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_valid  (pipe_valid),
        .pipe_regwen (pipe_regwen),
        .pipe_rd     (pipe_rd),
        .pipe_data   (pipe_data),
        .lu_valid    (lu_valid),
        .lu_rd       (lu_rd),
        .lu_data     (lu_data),
        .lu_ready    (lu_ready),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .rf_src      (rf_src),
        .pipe_stall  (pipe_stall)
    );

    // Reference model state: queued LU results in age order, head age, stall flag.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } entry_t;

    entry_t      q[$];
    int          waitCnt;
    bit          mStall;
    bit          expWe;
    logic [4:0]  expRd;
    logic [31:0] expData;
    bit          expSrc;
    bit          lastWasStall;
    bit          lastLuAcc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        waitCnt      = 0;
        mStall       = 0;
        expWe        = 0;
        expRd        = '0;
        expData      = '0;
        expSrc       = 0;
        lastWasStall = 0;
        lastLuAcc    = 0;
    endtask

    // Apply one cycle of the arbitration rules to the currently driven inputs.
    task automatic modelStep();
        bit          pAct, pGrant, luAcc, headOk, doPop, bypass, grant, nextStall;
        logic [4:0]  gRd;
        logic [31:0] gData;
        bit          gSrc;
        entry_t      e;
        pAct   = pipe_valid && pipe_regwen && (pipe_rd != 0);
        pGrant = pAct && !mStall;
        luAcc  = lu_valid && (q.size() < 2);
        headOk = (q.size() > 0) && q[0].live;
        doPop = 0; bypass = 0; grant = 0; gRd = '0; gData = '0; gSrc = 0;
        if (pGrant) begin
            grant = 1; gRd = pipe_rd; gData = pipe_data; gSrc = 0;
        end else if (q.size() > 0) begin
            doPop = 1;
            if (headOk) begin
                grant = 1; gRd = q[0].rd; gData = q[0].data; gSrc = 1;
            end
        end else if (luAcc && lu_rd != 0) begin
            bypass = 1; grant = 1; gRd = lu_rd; gData = lu_data; gSrc = 1;
        end
        nextStall = !mStall && headOk && !doPop && (waitCnt == LIMIT - 1)
                    && !(pGrant && q[0].rd == pipe_rd);
        if (doPop) waitCnt = 0;
        else if (headOk && waitCnt < 15) waitCnt++;
        if (pGrant) begin
            foreach (q[i]) if (q[i].rd == pipe_rd) q[i].live = 0;
        end
        if (doPop) void'(q.pop_front());
        if (luAcc && lu_rd != 0 && !bypass) begin
            e.rd = lu_rd; e.data = lu_data; e.live = !(pGrant && lu_rd == pipe_rd);
            q.push_back(e);
        end
        lastWasStall = mStall;
        lastLuAcc    = luAcc;
        mStall       = nextStall;
        expWe        = grant;
        if (grant) begin
            expRd = gRd; expData = gData; expSrc = gSrc;
            $display("WR rd=%0d data=0x%08h src=%0d t=%0t", gRd, gData, gSrc, $time);
        end
    endtask

    task automatic compareAll();
        check("rf_we", 32'(rf_we), 32'(expWe));
        check("rf_rd", 32'(rf_rd), 32'(expRd));
        check("rf_wdata", rf_wdata, expData);
        if (expWe) check("rf_src", 32'(rf_src), 32'(expSrc));
        check("pipe_stall", 32'(pipe_stall), 32'(mStall));
        check("lu_ready", 32'(lu_ready), 32'(q.size() < 2));
    endtask

    task automatic cycle(input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        pipe_valid = pv; pipe_regwen = 1'b1; pipe_rd = prd; pipe_data = pd;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    task automatic idle();
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        check({tag, "_rf_rd"}, 32'(rf_rd), 32'd0);
        check({tag, "_rf_wdata"}, rf_wdata, 32'd0);
        check({tag, "_rf_src"}, 32'(rf_src), 32'd0);
        check({tag, "_pipe_stall"}, 32'(pipe_stall), 32'd0);
        check({tag, "_lu_ready"}, 32'(lu_ready), 32'd1);
    endtask

    task automatic doReset();
        pipe_valid = 0; pipe_regwen = 0; pipe_rd = '0; pipe_data = '0;
        lu_valid = 0; lu_rd = '0; lu_data = '0;
        rst_n = 1'b0;
        modelReset();
        #2;
        checkResetValues("midreset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        pipe_valid = 0; pipe_regwen = 0; pipe_rd = '0; pipe_data = '0;
        lu_valid = 0; lu_rd = '0; lu_data = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;

        // LU result with idle pipe falls through to the port next cycle.
        cycle(0, 5'd0, 32'd0, 1, 5'd5, 32'h11);
        check("lu_only_we", 32'(rf_we), 32'd1);
        check("lu_only_rd", 32'(rf_rd), 32'd5);
        check("lu_only_data", rf_wdata, 32'h11);
        check("lu_only_src", 32'(rf_src), 32'd1);
        idle();
        check("hold_we", 32'(rf_we), 32'd0);
        check("hold_rd", 32'(rf_rd), 32'd5);

        // Pipe wins, LU follows one cycle later.
        cycle(1, 5'd3, 32'hAA, 1, 5'd7, 32'h77);
        check("both_pipe_rd", 32'(rf_rd), 32'd3);
        check("both_pipe_data", rf_wdata, 32'hAA);
        check("both_pipe_src", 32'(rf_src), 32'd0);
        idle();
        check("both_lu_rd", 32'(rf_rd), 32'd7);
        check("both_lu_src", 32'(rf_src), 32'd1);
        idle();

        // Starvation: queued rd=9 forces a stall after four denied cycles.
        cycle(1, 5'd1, 32'h101, 1, 5'd9, 32'h99);
        cycle(1, 5'd2, 32'h102, 0, 5'd0, 32'd0);
        cycle(1, 5'd3, 32'h103, 0, 5'd0, 32'd0);
        cycle(1, 5'd4, 32'h104, 0, 5'd0, 32'd0);
        check("starve_no_stall_yet", 32'(pipe_stall), 32'd0);
        cycle(1, 5'd5, 32'h105, 0, 5'd0, 32'd0);
        check("starve_stall", 32'(pipe_stall), 32'd1);
        check("starve_pipe_rd", 32'(rf_rd), 32'd5);
        cycle(1, 5'd6, 32'h106, 0, 5'd0, 32'd0);
        check("force_lu_rd", 32'(rf_rd), 32'd9);
        check("force_lu_src", 32'(rf_src), 32'd1);
        check("force_stall_done", 32'(pipe_stall), 32'd0);
        cycle(1, 5'd6, 32'h106, 0, 5'd0, 32'd0);
        check("replay_rd", 32'(rf_rd), 32'd6);
        check("replay_data", rf_wdata, 32'h106);
        idle();

        // Full queue back-pressure.
        cycle(1, 5'd1, 32'h201, 1, 5'd10, 32'hA0);
        cycle(1, 5'd2, 32'h202, 1, 5'd11, 32'hB0);
        check("full_ready0", 32'(lu_ready), 32'd0);
        cycle(1, 5'd3, 32'h203, 1, 5'd12, 32'hC0);
        check("full_ready0_held", 32'(lu_ready), 32'd0);
        cycle(0, 5'd0, 32'd0, 1, 5'd12, 32'hC0);
        check("pop_rd10", 32'(rf_rd), 32'd10);
        check("pop_ready1", 32'(lu_ready), 32'd1);
        cycle(0, 5'd0, 32'd0, 1, 5'd12, 32'hC0);
        check("pop_rd11", 32'(rf_rd), 32'd11);
        idle();
        check("third_rd12", 32'(rf_rd), 32'd12);
        check("third_data", rf_wdata, 32'hC0);
        idle();

        // WAW: younger pipe write squashes the queued rd=4 result.
        cycle(1, 5'd1, 32'h301, 1, 5'd4, 32'h44);
        cycle(1, 5'd4, 32'h4444, 0, 5'd0, 32'd0);
        check("waw_rd", 32'(rf_rd), 32'd4);
        check("waw_data", rf_wdata, 32'h4444);
        idle();
        check("waw_no_write", 32'(rf_we), 32'd0);
        check("waw_drained", 32'(lu_ready), 32'd1);
        idle();
        check("waw_data_kept", rf_wdata, 32'h4444);

        // Reset with two entries queued discards them.
        cycle(1, 5'd1, 32'h401, 1, 5'd20, 32'h14);
        cycle(1, 5'd2, 32'h402, 1, 5'd21, 32'h15);
        check("pre_reset_full", 32'(lu_ready), 32'd0);
        doReset();
        idle();
        idle();
        idle();
        check("post_reset_no_write", 32'(rf_we), 32'd0);

        // Randomized traffic with a small rd range to provoke WAW and starvation.
        for (int i = 0; i < 1500; i++) begin
            int pProb;
            pProb = ((i / 250) % 2 == 1) ? 90 : 40;
            if (i == 800) doReset();
            if (!lastWasStall) begin
                pipe_valid  = ($urandom_range(0, 99) < pProb);
                pipe_regwen = ($urandom_range(0, 9) != 0);
                pipe_rd     = 5'($urandom_range(0, 7));
                pipe_data   = $urandom;
            end
            if (!(lu_valid && !lastLuAcc)) begin
                lu_valid = ($urandom_range(0, 99) < 45);
                lu_rd    = 5'($urandom_range(0, 7));
                lu_data  = $urandom;
            end
            modelStep();
            @(negedge clk);
            compareAll();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
